// File: rtl/avmm_traffic_gen.sv
// Avalon-MM traffic generator: burst-writes a deterministic pattern into a region, reads it back, checks every beat.
// Optional build macro AVMM_TG_ERR_INJECT_EN adds input inject_err, which flips bit 0 of an accepted write beat.
module avmm_traffic_gen #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned BURST_W    = 7,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned NUM_BURSTS = 256,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned PATTERN    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cal_ok,
`ifdef AVMM_TG_ERR_INJECT_EN
    input  logic                inject_err,
`endif
    input  logic                avm_waitrequest_n,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [BURST_W-1:0]  avm_burstcount,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_read,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [31:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int unsigned        NL         = DATA_W / 32;
    localparam logic [BURST_W-1:0] LAST_BEAT  = BURST_W'(BURST_LEN - 1);
    localparam logic [31:0]        LAST_BURST = 32'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_STEP  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]        LFSR_TAPS  = 32'h8020_0003;  // x^32+x^22+x^2+x+1, right-shifting Galois form

    generate
        if (DATA_W % 32 != 0) begin : g_bad_data_w
            $error("DATA_W must be a multiple of 32");
        end
        if (BURST_LEN < 1 || BURST_LEN > (1 << (BURST_W - 1))) begin : g_bad_burst_len
            $error("BURST_LEN out of range 1..2^(BURST_W-1)");
        end
        if ((64'(NUM_BURSTS) * 64'(BURST_LEN)) > (64'd1 << ADDR_W)) begin : g_bad_region
            $error("NUM_BURSTS*BURST_LEN exceeds the address space");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_DONE} state_e;

    function automatic logic [DATA_W-1:0] pattern_seed();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int j = 0; j < NL; j++) begin
            w[j*32 +: 32] = (PATTERN == 0) ? 32'(j) : 32'hACE1_0000 + 32'(j);
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] pattern_next(input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] w;
        logic [31:0]       lane;
        w = '0;
        for (int j = 0; j < NL; j++) begin
            lane = cur[j*32 +: 32];
            if (PATTERN == 0) lane = lane + 32'(NL);
            else              lane = lane[0] ? ((lane >> 1) ^ LFSR_TAPS) : (lane >> 1);
            w[j*32 +: 32] = lane;
        end
        return w;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        burst_q, burst_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wgen_q, wgen_d;
    logic [DATA_W-1:0]  cgen_q, cgen_d;
    logic [31:0]        err_q, err_d;
    logic [ADDR_W-1:0]  ferr_q, ferr_d;

    // NOTE: synchronous reset lives inside the clocked block; all state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            burst_q <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wgen_q  <= '0;
            cgen_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wgen_q  <= wgen_d;
            cgen_q  <= cgen_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    logic last_beat, last_burst;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);

    // NOTE: every next-state variable gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wgen_d  = wgen_q;
        cgen_d  = cgen_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && cal_ok) begin
                    state_d = S_WR;
                    burst_d = '0;
                    beat_d  = '0;
                    addr_d  = BASE;
                    wgen_d  = pattern_seed();
                    cgen_d  = pattern_seed();
                    err_d   = '0;
                    ferr_d  = '0;
                end
            end
            S_WR: begin
                if (avm_waitrequest_n) begin
                    wgen_d = pattern_next(wgen_q);
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = S_RD_REQ;
                            burst_d = '0;
                            addr_d  = BASE;
                        end else begin
                            burst_d = burst_q + 32'd1;
                            addr_d  = addr_q + ADDR_STEP;
                        end
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            S_RD_REQ: begin
                if (avm_waitrequest_n) begin
                    state_d = S_RD_WAIT;
                    beat_d  = '0;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    cgen_d = pattern_next(cgen_q);
                    if (avm_readdata != cgen_q) begin
                        if (err_q == 32'd0)     ferr_d = addr_q + ADDR_W'(beat_q);
                        if (err_q != '1)        err_d  = err_q + 32'd1;
                    end
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD_REQ;
                            burst_d = burst_q + 32'd1;
                            addr_d  = addr_q + ADDR_STEP;
                        end
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [DATA_W-1:0] inj_mask;
`ifdef AVMM_TG_ERR_INJECT_EN
    assign inj_mask = {{(DATA_W-1){1'b0}}, inject_err};
`else
    assign inj_mask = '0;
`endif

    logic wr_active, rd_active, req_active;
    assign wr_active  = (state_q == S_WR);
    assign rd_active  = (state_q == S_RD_REQ);
    assign req_active = wr_active || rd_active;

    // Request fields are zeroed outside a request so every output reads 0 after reset, even with a nonzero BASE_ADDR.
    assign avm_write      = wr_active;
    assign avm_read       = rd_active;
    assign avm_address    = req_active ? addr_q : '0;
    assign avm_burstcount = req_active ? BURST_W'(BURST_LEN) : '0;
    assign avm_byteenable = req_active ? '1 : '0;
    assign avm_writedata  = wr_active ? (wgen_q ^ inj_mask) : '0;

    assign busy           = wr_active || rd_active || (state_q == S_RD_WAIT);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == 32'd0);
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_avmm_traffic_gen.sv
// Directed bench for avmm_traffic_gen with a behavioural Avalon-MM memory that can stall, corrupt and emit stray beats.
// Building with AVMM_TG_ERR_INJECT_EN switches to the small LFSR configuration and runs the injection scenario.
module tb_avmm_traffic_gen;

`ifdef AVMM_TG_ERR_INJECT_EN
    localparam int PATTERN = 1, BURST_LEN = 1, NUM_BURSTS = 8;
`else
    localparam int PATTERN = 0, BURST_LEN = 4, NUM_BURSTS = 256;
`endif
    localparam int DATA_W = 128, ADDR_W = 27, BURST_W = 7, NL = DATA_W / 32;
    localparam int TOTAL = BURST_LEN * NUM_BURSTS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                cal_ok = 1'b1;
    logic                inject_err = 1'b0;
    logic                avm_waitrequest_n = 1'b1;
    logic [ADDR_W-1:0]   avm_address;
    logic [BURST_W-1:0]  avm_burstcount;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_read;
    logic [DATA_W-1:0]   avm_readdata = '0;
    logic                avm_readdatavalid = 1'b0;
    logic                busy, done, pass;
    logic [31:0]         err_count;
    logic [ADDR_W-1:0]   first_err_addr;

    avmm_traffic_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .BURST_LEN(BURST_LEN),
        .NUM_BURSTS(NUM_BURSTS), .BASE_ADDR(0), .PATTERN(PATTERN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cal_ok(cal_ok),
`ifdef AVMM_TG_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .avm_waitrequest_n(avm_waitrequest_n), .avm_address(avm_address),
        .avm_burstcount(avm_burstcount), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model state.
    logic [DATA_W-1:0]  mem [0:TOTAL-1];
    int                 wr_beats = 0, rd_bursts = 0, stable_err = 0;
    int                 wr_in_burst = 0, rd_pend = 0, rd_idx = 0, rd_addr = 0;
    int                 stall_mode = 0, cyc = 0, stray_n = 0, inject_beat = -1;
    bit                 corrupt_en = 1'b0;
    int                 corrupt_a = 0, corrupt_b = 0;
    bit                 prev_stalled = 1'b0, prev_w = 1'b0, prev_r = 1'b0;
    logic [ADDR_W-1:0]  prev_addr = '0;
    logic [BURST_W-1:0] prev_bc = '0;
    logic [DATA_W-1:0]  prev_data = '0;

    // Inputs are driven 1 unit after the falling edge, outputs sampled 1 unit later; both far from the rising edge.
    initial begin : mem_model
        logic [DATA_W-1:0] rdata;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                rd_pend = 0;
                wr_in_burst = 0;
                prev_stalled = 1'b0;
            end
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
            if (stray_n > 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = {NL{32'hDEAD_BEEF}};
                stray_n--;
            end else if (rd_pend > 0) begin
                rdata = mem[rd_addr + rd_idx];
                if (corrupt_en && ((rd_addr + rd_idx) == corrupt_a || (rd_addr + rd_idx) == corrupt_b))
                    rdata[7:0] = ~rdata[7:0];
                avm_readdatavalid = 1'b1;
                avm_readdata = rdata;
                rd_idx++;
                rd_pend--;
            end
            avm_waitrequest_n = (stall_mode == 0) || (cyc % 4 == 0);
            inject_err = avm_write && avm_waitrequest_n && (wr_beats == inject_beat);
            #1;
            if (prev_stalled && (avm_write !== prev_w || avm_read !== prev_r || avm_address !== prev_addr ||
                                 avm_burstcount !== prev_bc || avm_writedata !== prev_data))
                stable_err++;
            prev_stalled = rst_n && (avm_write || avm_read) && !avm_waitrequest_n;
            prev_w = avm_write;
            prev_r = avm_read;
            prev_addr = avm_address;
            prev_bc = avm_burstcount;
            prev_data = avm_writedata;
            if (rst_n && avm_write && avm_waitrequest_n) begin
                mem[int'(avm_address) + wr_in_burst] = avm_writedata;
                wr_beats++;
                wr_in_burst = (wr_in_burst == BURST_LEN - 1) ? 0 : wr_in_burst + 1;
            end
            if (rst_n && avm_read && avm_waitrequest_n) begin
                rd_bursts++;
                rd_addr = int'(avm_address);
                rd_idx = 0;
                rd_pend = int'(avm_burstcount);
            end
        end
    end

    function automatic logic [DATA_W-1:0] exp_word(input int k);
        logic [DATA_W-1:0] w;
        logic [31:0]       s;
        for (int j = 0; j < NL; j++) begin
            if (PATTERN == 0) begin
                s = 32'(k * NL + j);
            end else begin
                s = 32'hACE1_0000 + 32'(j);
                for (int n = 0; n < k; n++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
            end
            w[j*32 +: 32] = s;
        end
        return w;
    endfunction

    task automatic clear_counts();
        wr_beats = 0;
        rd_bursts = 0;
        stable_err = 0;
    endtask

    task automatic pulse_start(input logic cal);
        @(negedge clk);
        cal_ok = cal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cal_ok = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles (done=%b)", name, budget, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (pass !== 1'b0)      begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass); end
        n_tests++; if (err_count !== 32'd0) begin n_fail++; $display("FAIL reset_err: got %h want 0", err_count); end
        n_tests++; if (first_err_addr !== '0) begin n_fail++; $display("FAIL reset_ferr: got %h want 0", first_err_addr); end
        n_tests++; if (avm_write !== 1'b0 || avm_read !== 1'b0)
            begin n_fail++; $display("FAIL reset_req: got wr=%b rd=%b want 0 0", avm_write, avm_read); end
        n_tests++; if (avm_address !== '0 || avm_burstcount !== '0)
            begin n_fail++; $display("FAIL reset_addr_bc: got %h/%h want 0/0", avm_address, avm_burstcount); end
        n_tests++; if (avm_byteenable !== '0 || avm_writedata !== '0)
            begin n_fail++; $display("FAIL reset_be_wd: got %h/%h want 0/0", avm_byteenable, avm_writedata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef AVMM_TG_ERR_INJECT_EN
    task automatic test_inject();
        logic [DATA_W-1:0] w3;
        clear_counts();
        inject_beat = 3;
        pulse_start(1'b1);
        wait_done(500, "inject_done");
        inject_beat = -1;
        w3 = exp_word(3);
        n_tests++; if (err_count !== 32'd1) begin n_fail++; $display("FAIL inject_err_count: got %0d want 1", err_count); end
        n_tests++; if (first_err_addr !== 27'd3) begin n_fail++; $display("FAIL inject_first_addr: got %h want 3", first_err_addr); end
        n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL inject_pass: got %b want 0", pass); end
        n_tests++; if (mem[3][31:0] !== (w3[31:0] ^ 32'd1))
            begin n_fail++; $display("FAIL inject_beat3_lane0: got %h want %h", mem[3][31:0], w3[31:0] ^ 32'd1); end
        n_tests++; if (mem[3][63:32] !== w3[63:32])
            begin n_fail++; $display("FAIL inject_beat3_lane1: got %h want %h", mem[3][63:32], w3[63:32]); end
        n_tests++; if (mem[2] !== exp_word(2))
            begin n_fail++; $display("FAIL inject_beat2: got %h want %h", mem[2], exp_word(2)); end
        n_tests++; if (wr_beats !== 8) begin n_fail++; $display("FAIL inject_wr_beats: got %0d want 8", wr_beats); end
    endtask
`else
    task automatic test_basic();
        int bad;
        clear_counts();
        pulse_start(1'b1);
        n_tests++; if (avm_write !== 1'b1 || busy !== 1'b1)
            begin n_fail++; $display("FAIL basic_latency: got wr=%b busy=%b want 1 1", avm_write, busy); end
        n_tests++; if (avm_address !== '0 || avm_burstcount !== 7'd4)
            begin n_fail++; $display("FAIL basic_first_req: got addr=%h bc=%0d want 0 4", avm_address, avm_burstcount); end
        n_tests++; if (avm_byteenable !== 16'hFFFF || avm_writedata !== 128'h00000003_00000002_00000001_00000000)
            begin n_fail++; $display("FAIL basic_first_beat: got be=%h wd=%h want ffff/3_2_1_0", avm_byteenable, avm_writedata); end
        wait_done(6000, "basic_done");
        n_tests++; if (pass !== 1'b1 || err_count !== 32'd0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL basic_result: got pass=%b err=%0d busy=%b want 1 0 0", pass, err_count, busy); end
        n_tests++; if (wr_beats !== 1024 || rd_bursts !== 256)
            begin n_fail++; $display("FAIL basic_counts: got wr=%0d rd=%0d want 1024 256", wr_beats, rd_bursts); end
        n_tests++; if (mem[5][95:64] !== 32'h16)
            begin n_fail++; $display("FAIL basic_beat5_lane2: got %h want 00000016", mem[5][95:64]); end
        n_tests++; if (mem[1023][127:96] !== 32'hFFF)
            begin n_fail++; $display("FAIL basic_last_word: got %h want 00000fff", mem[1023][127:96]); end
        bad = 0;
        for (int k = 0; k < TOTAL; k++) if (mem[k] !== exp_word(k)) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL basic_memory: got %0d bad words want 0", bad); end
    endtask

    task automatic test_corrupt();
        clear_counts();
        corrupt_en = 1'b1;
        corrupt_a = 'h41;
        corrupt_b = 'h80;
        pulse_start(1'b1);
        wait_done(6000, "corrupt_done");
        corrupt_en = 1'b0;
        n_tests++; if (err_count !== 32'd2) begin n_fail++; $display("FAIL corrupt_err_count: got %0d want 2", err_count); end
        n_tests++; if (first_err_addr !== 27'h41) begin n_fail++; $display("FAIL corrupt_first_addr: got %h want 41", first_err_addr); end
        n_tests++; if (pass !== 1'b0 || done !== 1'b1)
            begin n_fail++; $display("FAIL corrupt_pass: got pass=%b done=%b want 0 1", pass, done); end
    endtask

    task automatic test_stall();
        clear_counts();
        stall_mode = 1;
        pulse_start(1'b1);
        n_tests++; if (done !== 1'b0 || err_count !== 32'd0 || first_err_addr !== '0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL stall_restart_clear: got done=%b err=%0d ferr=%h busy=%b want 0 0 0 1",
                                     done, err_count, first_err_addr, busy); end
        wait_done(20000, "stall_done");
        stall_mode = 0;
        n_tests++; if (stable_err !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes want 0", stable_err); end
        n_tests++; if (wr_beats !== 1024) begin n_fail++; $display("FAIL stall_wr_beats: got %0d want 1024", wr_beats); end
        n_tests++; if (pass !== 1'b1 || err_count !== 32'd0)
            begin n_fail++; $display("FAIL stall_result: got pass=%b err=%0d want 1 0", pass, err_count); end
    endtask

    task automatic test_reset_mid_pass();
        bit seen;
        clear_counts();
        pulse_start(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rd_bursts >= 11) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL midreset_reach_burst10: got %0d bursts want 11", rd_bursts); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++; if (busy !== 1'b0 || avm_read !== 1'b0 || err_count !== 32'd0)
            begin n_fail++; $display("FAIL midreset_state: got busy=%b rd=%b err=%0d want 0 0 0", busy, avm_read, err_count); end
        stray_n = 5;
        repeat (8) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || err_count !== 32'd0 || first_err_addr !== '0)
            begin n_fail++; $display("FAIL midreset_stray: got busy=%b done=%b err=%0d ferr=%h want 0 0 0 0",
                                     busy, done, err_count, first_err_addr); end
        clear_counts();
        pulse_start(1'b1);
        wait_done(6000, "midreset_fresh_done");
        n_tests++; if (pass !== 1'b1 || err_count !== 32'd0 || wr_beats !== 1024)
            begin n_fail++; $display("FAIL midreset_fresh: got pass=%b err=%0d wr=%0d want 1 0 1024", pass, err_count, wr_beats); end
    endtask

    task automatic test_ignored_start();
        pulse_start(1'b0);
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done !== 1'b1)
            begin n_fail++; $display("FAIL ignore_calok: got busy=%b done=%b want 0 1", busy, done); end
        clear_counts();
        pulse_start(1'b1);
        repeat (20) @(negedge clk);
        pulse_start(1'b1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_state: got busy=%b want 1", busy); end
        wait_done(6000, "ignore_busy_done");
        n_tests++; if (wr_beats !== 1024 || rd_bursts !== 256 || pass !== 1'b1)
            begin n_fail++; $display("FAIL ignore_busy_result: got wr=%0d rd=%0d pass=%b want 1024 256 1", wr_beats, rd_bursts, pass); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AVMM_TG_ERR_INJECT_EN
        test_inject();
`else
        test_basic();
        test_corrupt();
        test_stall();
        test_reset_mid_pass();
        test_ignored_start();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
